// File: rtl/rv_pkg.sv
// Shared pipeline definitions: datapath width, ALU opcodes and forwarding selects.
package rv_pkg;
  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_EXM  = 2'd1,
    FWD_MWB  = 2'd2
  } fwd_sel_t;
endpackage

// File: rtl/fwd_unit.sv
// Operand bypass select: the youngest in-flight writer of a non-zero register wins.
module fwd_unit
  import rv_pkg::*;
(
  input  logic [4:0] rs_addr,
  input  logic       exm_reg_write,
  input  logic [4:0] exm_rd_addr,
  input  logic       mwb_reg_write,
  input  logic [4:0] mwb_rd_addr,
  output fwd_sel_t   sel
);
  always_comb begin
    sel = FWD_NONE;
    if (rs_addr != 5'd0) begin
      if (exm_reg_write && (exm_rd_addr == rs_addr)) begin
        sel = FWD_EXM;
      end else if (mwb_reg_write && (mwb_rd_addr == rs_addr)) begin
        sel = FWD_MWB;
      end
    end
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, flush and operand forwarding.
module id_ex_stage #(
  parameter int XLEN = rv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [4:0]      id_rs1_addr,
  input  logic [4:0]      id_rs2_addr,
  input  logic [4:0]      id_rd_addr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [3:0]      id_alu_control,
  input  logic            id_alu_src_a,
  input  logic            id_alu_src_b,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            flush,
  input  logic            exm_reg_write,
  input  logic [4:0]      exm_rd_addr,
  input  logic [XLEN-1:0] exm_result,
  input  logic            mwb_reg_write,
  input  logic [4:0]      mwb_rd_addr,
  input  logic [XLEN-1:0] mwb_result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_control,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rd_addr,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic [XLEN-1:0] ex_store_data,
  output logic            stall_id,
  output logic [31:0]     stall_count
);
  import rv_pkg::*;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [4:0]      rs1_addr_q, rs1_addr_d;
  logic [4:0]      rs2_addr_q, rs2_addr_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [3:0]      alu_ctrl_q, alu_ctrl_d;
  logic            src_a_q, src_a_d;
  logic            src_b_q, src_b_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic [31:0]     stall_count_q, stall_count_d;

  logic            bubble;
  fwd_sel_t        sel_rs1, sel_rs2;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;

  assign stall_id = id_valid && valid_q && mem_read_q && (rd_addr_q != 5'd0) &&
                    ((rd_addr_q == id_rs1_addr) || (rd_addr_q == id_rs2_addr));
  assign bubble   = flush || stall_id || !id_valid;

  // Data fields are captured even for bubbles so they stay X-free; only control is squashed.
  always_comb begin
    pc_d        = id_pc;
    rs1_addr_d  = id_rs1_addr;
    rs2_addr_d  = id_rs2_addr;
    rd_addr_d   = id_rd_addr;
    rs1_data_d  = id_rs1_data;
    rs2_data_d  = id_rs2_data;
    imm_d       = id_imm;
    src_a_d     = id_alu_src_a;
    src_b_d     = id_alu_src_b;
    valid_d     = id_valid;
    alu_ctrl_d  = id_alu_control;
    reg_write_d = id_reg_write;
    mem_read_d  = id_mem_read;
    mem_write_d = id_mem_write;
    if (bubble) begin
      valid_d     = 1'b0;
      alu_ctrl_d  = ALU_ADD;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end
    stall_count_d = stall_count_q;
    if (stall_id && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= 1'b0;
      pc_q          <= '0;
      rs1_addr_q    <= '0;
      rs2_addr_q    <= '0;
      rd_addr_q     <= '0;
      rs1_data_q    <= '0;
      rs2_data_q    <= '0;
      imm_q         <= '0;
      alu_ctrl_q    <= ALU_ADD;
      src_a_q       <= 1'b0;
      src_b_q       <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      stall_count_q <= '0;
    end else begin
      valid_q       <= valid_d;
      pc_q          <= pc_d;
      rs1_addr_q    <= rs1_addr_d;
      rs2_addr_q    <= rs2_addr_d;
      rd_addr_q     <= rd_addr_d;
      rs1_data_q    <= rs1_data_d;
      rs2_data_q    <= rs2_data_d;
      imm_q         <= imm_d;
      alu_ctrl_q    <= alu_ctrl_d;
      src_a_q       <= src_a_d;
      src_b_q       <= src_b_d;
      reg_write_q   <= reg_write_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      stall_count_q <= stall_count_d;
    end
  end

  fwd_unit u_fwd_rs1 (
    .rs_addr       (rs1_addr_q),
    .exm_reg_write (exm_reg_write),
    .exm_rd_addr   (exm_rd_addr),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd_addr   (mwb_rd_addr),
    .sel           (sel_rs1)
  );

  fwd_unit u_fwd_rs2 (
    .rs_addr       (rs2_addr_q),
    .exm_reg_write (exm_reg_write),
    .exm_rd_addr   (exm_rd_addr),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd_addr   (mwb_rd_addr),
    .sel           (sel_rs2)
  );

  always_comb begin
    case (sel_rs1)
      FWD_EXM: rs1_fwd = exm_result;
      FWD_MWB: rs1_fwd = mwb_result;
      default: rs1_fwd = rs1_data_q;
    endcase
    case (sel_rs2)
      FWD_EXM: rs2_fwd = exm_result;
      FWD_MWB: rs2_fwd = mwb_result;
      default: rs2_fwd = rs2_data_q;
    endcase
  end

  assign alu_a         = src_a_q ? pc_q : rs1_fwd;
  assign alu_b         = src_b_q ? imm_q : rs2_fwd;
  assign alu_control   = alu_ctrl_q;
  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_rd_addr    = rd_addr_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_store_data = rs2_fwd;
  assign stall_count   = stall_count_q;
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Ports id_valid in 1, id_pc in XLEN, id_rs1_addr/id_rs2_addr/id_rd_addr in 5, id_rs1_data/id_rs2_data/id_imm in XLEN: decoded instruction from ID.
REQ-005 Ports id_alu_control in 4 (ALU opcode), id_alu_src_a in 1 (0=rs1, 1=pc), id_alu_src_b in 1 (0=rs2, 1=imm), id_reg_write/id_mem_read/id_mem_write in 1: control bits.
REQ-006 Port flush  in  1  branch-taken kill of the instruction entering EX.
REQ-007 Ports exm_reg_write in 1, exm_rd_addr in 5, exm_result in XLEN: EX/MEM forwarding source.
REQ-008 Ports mwb_reg_write in 1, mwb_rd_addr in 5, mwb_result in XLEN: MEM/WB forwarding source.
REQ-009 Ports alu_a/alu_b out XLEN, alu_control out 4: drive ALU a, b, alu_control directly.
REQ-010 Ports ex_valid out 1, ex_pc out XLEN, ex_rd_addr out 5, ex_reg_write/ex_mem_read/ex_mem_write out 1, ex_store_data out XLEN: EX-stage payload.
REQ-011 Port stall_id  out 1  holds IF/ID when high; stall_count out 32 saturating count of stall cycles.

Function
REQ-012 Pipeline register captures all id_* fields on each rising clk; latency exactly one cycle ID->EX.
REQ-013 Load-use hazard: stall_id = id_valid & ex_valid & ex_mem_read & (ex_rd_addr != 0) & (ex_rd_addr == id_rs1_addr | ex_rd_addr == id_rs2_addr); combinational.
REQ-014 On stall_id high: register loads a bubble (ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_mem_write=0, alu_control=ADD); ID inputs held by upstream.
REQ-015 On flush high: register loads a bubble regardless of stall_id; flush has priority over stall and over id_valid.
REQ-016 If id_valid low, register loads a bubble.
REQ-017 Forwarding per operand (registered rs1/rs2 addr): EX/MEM match (exm_reg_write, exm_rd_addr != 0, addr equal) wins; else MEM/WB match; else registered register-file data.
REQ-018 Register x0 never forwarded; operand with addr 0 uses registered data.
REQ-019 alu_a = pc if src_a else forwarded rs1; alu_b = imm if src_b else forwarded rs2; combinational from registered state.
REQ-020 ex_store_data = forwarded rs2 regardless of src_b.
REQ-021 Bubble control bits forced low; data fields in a bubble are don't-care but stable (unchanged X-free).
REQ-022 stall_count increments by 1 per cycle with stall_id high, saturates at 32'hFFFFFFFF, never wraps.
REQ-023 Simultaneous flush and stall: bubble inserted, stall_count still increments, stall_id still asserted.

Reset
REQ-024 On rst: ex_valid=0, all control outputs 0, alu_control=ADD (4'b0000), all data registers 0, stall_count=0.
REQ-025 rst mid-stall: next cycle holds reset values; stall_id thereafter recomputed from ex_valid=0, so deasserts.
REQ-026 rst overrides flush, stall and id_valid.

Structure
REQ-027 Shared package rv_pkg holds XLEN, ALU opcode constants (ALU_ADD=4'b0000, ALU_SUB=4'b0001, ...) and fwd_sel_t enum {FWD_NONE, FWD_EXM, FWD_MWB}.
REQ-028 One sub-module fwd_unit: pure combinational select generator, instantiated once per operand.

Verification
REQ-029 ID: rs1=x1 data 5, rs2=x2 data 7, ADD, src_b=0 -> next cycle alu_a=5, alu_b=7, alu_control=0000, ex_valid=1.
REQ-030 EX: rs1=x3; exm rd=x3 result 32'h40000000, mwb rd=x3 result 1, both reg_write -> alu_a=32'h40000000 (EX/MEM priority).
REQ-031 EX rs1=x0, exm rd=x0 result 99, reg_write=1 -> alu_a=registered rs1 data (0), no forward.
REQ-032 EX holds load rd=x5; ID rs2=x5 valid -> stall_id=1 one cycle, following cycle ex_valid=0, stall_count=1; on retry alu_b=mwb_result.
REQ-033 flush=1 with valid SUB in ID -> next cycle ex_valid=0, ex_reg_write=0, alu_control=0000.
REQ-034 stall_count preloaded near max via 2^32 stalls (force) -> stays 32'hFFFFFFFF; rst -> 0, ex_valid=0.
